// File: rtl/kj_width_buffer.sv
// Circular word buffer: K words in, J words out, WIDTH bits per word.
// Optional sticky error flag for rejected requests when KJ_BUF_ERR_EN is defined.
module kj_width_buffer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned K     = 4,
  parameter int unsigned J     = 4,
  parameter int unsigned DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               w_en,
  input  logic               r_en,
  input  logic [WIDTH*K-1:0] par_in,
  output logic [WIDTH*J-1:0] par_out,
  output logic               empty,
  output logic               ready,
  output logic               full,
`ifdef KJ_BUF_ERR_EN
  output logic               err,
`endif
  output logic               valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, wptr_d;
  logic [AW-1:0]      rptr_q, rptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WIDTH*J-1:0] par_out_q, par_out_d;
  logic               valid_q, valid_d;
  logic               w_acc, r_ok, r_acc;

  // Status flags derive from the registered occupancy only.
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign ready = ((CW'(DEPTH) - count_q) >= CW'(K));
  assign r_ok  = (count_q >= CW'(J));
  assign w_acc = w_en & ready;
  assign r_acc = r_en & r_ok;

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    par_out_d = par_out_q;
    valid_d   = 1'b0;
    count_d   = count_q + (w_acc ? CW'(K) : '0) - (r_acc ? CW'(J) : '0);
    if (w_acc) begin
      wptr_d = wptr_q + AW'(K);
    end
    if (r_acc) begin
      rptr_d  = rptr_q + AW'(J);
      valid_d = 1'b1;
      for (int unsigned j = 0; j < J; j++) begin
        par_out_d[j*WIDTH +: WIDTH] = mem_q[rptr_q + AW'(j)];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      par_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      par_out_q <= par_out_d;
      valid_q   <= valid_d;
    end
  end

  // Storage is not reset; occupancy alone decides what is live.
  always_ff @(posedge clk) begin
    if (w_acc) begin
      for (int unsigned i = 0; i < K; i++) begin
        mem_q[wptr_q + AW'(i)] <= par_in[i*WIDTH +: WIDTH];
      end
    end
  end

  assign par_out = par_out_q;
  assign valid   = valid_q;

`ifdef KJ_BUF_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (w_en & ~ready) | (r_en & ~r_ok);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_kj_width_buffer.sv
// Randomised and directed bench for kj_width_buffer against a word-queue model.
// Instance a uses default parameters; instance b uses J=2 for width conversion.
module tb_kj_width_buffer;

  logic        clk;
  logic        rst;
  logic        w_en, r_en;
  logic [31:0] par_in;
  logic [31:0] par_out;
  logic        empty, ready, full, valid;
  logic        w_en_b, r_en_b;
  logic [31:0] par_in_b;
  logic [15:0] par_out_b;
  logic        empty_b, ready_b, full_b, valid_b;
`ifdef KJ_BUF_ERR_EN
  logic        err, err_b;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: FIFO of words plus expected registered outputs.
  logic [7:0]  q[$];
  logic [31:0] exp_par;
  logic        exp_valid;
  logic        exp_err;

  kj_width_buffer #(.WIDTH(8), .K(4), .J(4), .DEPTH(16)) u_a (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .par_in(par_in),
    .par_out(par_out), .empty(empty), .ready(ready), .full(full),
`ifdef KJ_BUF_ERR_EN
    .err(err),
`endif
    .valid(valid)
  );

  kj_width_buffer #(.WIDTH(8), .K(4), .J(2), .DEPTH(16)) u_b (
    .clk(clk), .rst(rst), .w_en(w_en_b), .r_en(r_en_b), .par_in(par_in_b),
    .par_out(par_out_b), .empty(empty_b), .ready(ready_b), .full(full_b),
`ifdef KJ_BUF_ERR_EN
    .err(err_b),
`endif
    .valid(valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b0;
    w_en = 1'b0; r_en = 1'b0; par_in = '0;
    w_en_b = 1'b0; r_en_b = 1'b0; par_in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    q.delete();
    exp_par = '0;
    exp_valid = 1'b0;
    exp_err = 1'b0;
    #1;
  endtask

  // Drive one cycle on instance a and advance the model; sampling is 1 time unit after the edge.
  task automatic step(input logic w, input logic r, input logic [31:0] d);
    int  cnt;
    logic wacc, racc;
    w_en = w; r_en = r; par_in = d;
    @(posedge clk);
    cnt  = q.size();
    wacc = w && ((16 - cnt) >= 4);
    racc = r && (cnt >= 4);
    if ((w && !wacc) || (r && !racc)) exp_err = 1'b1;
    exp_valid = racc;
    if (racc) for (int j = 0; j < 4; j++) exp_par[j*8 +: 8] = q.pop_front();
    if (wacc) for (int i = 0; i < 4; i++) q.push_back(d[i*8 +: 8]);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    w_en = 1'b0; r_en = 1'b0; par_in = '0;
    w_en_b = 1'b0; r_en_b = 1'b0; par_in_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    q.delete(); exp_par = '0; exp_valid = 1'b0; exp_err = 1'b0;
    checks++; if ({empty, full, ready, valid} !== 4'b1010) begin
      errors++; $display("FAIL reset_status got e/f/r/v=%b exp=1010", {empty, full, ready, valid});
    end
    checks++; if (par_out !== 32'h0) begin
      errors++; $display("FAIL reset_par_out got=%h exp=00000000", par_out);
    end
`ifdef KJ_BUF_ERR_EN
    checks++; if (err !== 1'b0) begin
      errors++; $display("FAIL reset_err got=%b exp=0", err);
    end
`endif
  endtask

  task automatic test_fill();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, {8'd10, 8'd15, 8'd25, 8'd12});
`ifdef KJ_BUF_ERR_EN
      checks++; if (err !== (i >= 4)) begin
        errors++; $display("FAIL fill_err cyc=%0d got=%b exp=%b", i, err, (i >= 4));
      end
`endif
    end
    checks++; if ({empty, full, ready, valid} !== 4'b0100) begin
      errors++; $display("FAIL fill_status got e/f/r/v=%b exp=0100", {empty, full, ready, valid});
    end
  endtask

  task automatic test_read_after_fill();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 32'h0);
      checks++; if (valid !== 1'b1 || par_out !== 32'h0A0F190C) begin
        errors++; $display("FAIL raf_data rd=%0d got v=%b d=%h exp v=1 d=0a0f190c", i, valid, par_out);
      end
    end
    step(1'b0, 1'b0, 32'h0);
    checks++; if ({empty, full, ready, valid} !== 4'b0010) begin
      errors++; $display("FAIL raf_status got e/f/r/v=%b exp=0010", {empty, full, ready, valid});
    end
    checks++; if (par_out !== 32'h0A0F190C) begin
      errors++; $display("FAIL raf_hold got=%h exp=0a0f190c", par_out);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b1, 1'b0, 32'h44332211);
    step(1'b1, 1'b1, 32'h88776655);
    checks++; if (valid !== 1'b1 || par_out !== exp_par) begin
      errors++; $display("FAIL simul12_data got v=%b d=%h exp v=1 d=%h", valid, par_out, exp_par);
    end
    checks++; if ({full, ready} !== 2'b01) begin
      errors++; $display("FAIL simul12_status got f/r=%b exp=01", {full, ready});
    end
    step(1'b1, 1'b0, 32'hCCBBAA99);
    checks++; if (full !== 1'b1) begin
      errors++; $display("FAIL simul16_full got=%b exp=1", full);
    end
    step(1'b1, 1'b1, 32'hDEADBEEF);
    checks++; if (valid !== 1'b1 || par_out !== exp_par) begin
      errors++; $display("FAIL simul16_data got v=%b d=%h exp v=1 d=%h", valid, par_out, exp_par);
    end
    checks++; if ({full, ready, empty} !== 3'b010) begin
      errors++; $display("FAIL simul16_status got f/r/e=%b exp=010", {full, ready, empty});
    end
    // Drain so the wrap test starts from a known empty state.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h0);
    checks++; if (empty !== 1'b1 || par_out !== exp_par) begin
      errors++; $display("FAIL simul_drain got e=%b d=%h exp e=1 d=%h", empty, par_out, exp_par);
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  n;
    logic [31:0] d;
    n = 8'd1;
    for (int i = 0; i < 30; i++) begin
      d = {n + 8'd3, n + 8'd2, n + 8'd1, n};
      if ((i % 3) != 2) n = n + 8'd4;
      step((i % 3) != 2, (i % 3) != 0, d);
      checks++; if (valid !== exp_valid || par_out !== exp_par) begin
        errors++; $display("FAIL wrap cyc=%0d got v=%b d=%h exp v=%b d=%h", i, valid, par_out, exp_valid, exp_par);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      checks++; if (valid !== exp_valid || par_out !== exp_par) begin
        errors++; $display("FAIL rand_data cyc=%0d got v=%b d=%h exp v=%b d=%h", i, valid, par_out, exp_valid, exp_par);
      end
      checks++; if ({empty, full, ready} !== {q.size() == 0, q.size() == 16, q.size() <= 12}) begin
        errors++; $display("FAIL rand_status cyc=%0d got e/f/r=%b occupancy=%0d", i, {empty, full, ready}, q.size());
      end
`ifdef KJ_BUF_ERR_EN
      checks++; if (err !== exp_err) begin
        errors++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", i, err, exp_err);
      end
`endif
    end
  endtask

  task automatic test_width_conv();
    do_reset();
    w_en_b = 1'b1; par_in_b = 32'h04030201;
    @(posedge clk); #1;
    w_en_b = 1'b0; r_en_b = 1'b1;
    checks++; if (empty_b !== 1'b0) begin
      errors++; $display("FAIL wc_write got empty=%b exp=0", empty_b);
    end
    @(posedge clk); #1;
    checks++; if (valid_b !== 1'b1 || par_out_b !== 16'h0201) begin
      errors++; $display("FAIL wc_rd0 got v=%b d=%h exp v=1 d=0201", valid_b, par_out_b);
    end
    @(posedge clk); #1;
    checks++; if (valid_b !== 1'b1 || par_out_b !== 16'h0403) begin
      errors++; $display("FAIL wc_rd1 got v=%b d=%h exp v=1 d=0403", valid_b, par_out_b);
    end
    @(posedge clk); #1;
    r_en_b = 1'b0;
    checks++; if (valid_b !== 1'b0 || par_out_b !== 16'h0403 || empty_b !== 1'b1) begin
      errors++; $display("FAIL wc_rd2 got v=%b d=%h e=%b exp v=0 d=0403 e=1", valid_b, par_out_b, empty_b);
    end
`ifdef KJ_BUF_ERR_EN
    checks++; if (err_b !== 1'b1) begin
      errors++; $display("FAIL wc_err got=%b exp=1", err_b);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h11223344 + 32'(i));
    step(1'b0, 1'b1, 32'h0);
    checks++; if (valid !== 1'b1 || par_out !== 32'h11223344) begin
      errors++; $display("FAIL mid_pre got v=%b d=%h exp v=1 d=11223344", valid, par_out);
    end
    w_en = 1'b0; r_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++; if ({empty, full, ready, valid} !== 4'b1010 || par_out !== 32'h0) begin
      errors++; $display("FAIL mid_reset got e/f/r/v=%b d=%h exp 1010 d=00000000", {empty, full, ready, valid}, par_out);
    end
    @(posedge clk); #1 rst = 1'b1;
    q.delete(); exp_par = '0; exp_valid = 1'b0; exp_err = 1'b0;
    step(1'b0, 1'b1, 32'h0);
    checks++; if (valid !== 1'b0 || empty !== 1'b1) begin
      errors++; $display("FAIL mid_after got v=%b e=%b exp v=0 e=1", valid, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_read_after_fill();
    test_simultaneous();
    test_wrap();
    test_random();
    test_width_conv();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kj_width_buffer.md
Name: kj_width_buffer

Overview:
- Circular word buffer with a K-words-in / J-words-out parallel interface, each word WIDTH bits.
- Sits between a K-wide producer and a J-wide consumer as a width-converting FIFO.
- Exposes flow-control status: ready, valid, empty, full.

Parameters:
- WIDTH, 8, bits per word.
- K, 4, words accepted per write.
- J, 4, words delivered per read.
- DEPTH, 16, buffer capacity in words. Must be a power of two and at least max(K,J).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- w_en  input  1  write request.
- r_en  input  1  read request.
- par_in  input  WIDTH*K  K input words; word i is par_in[i*WIDTH +: WIDTH]; word 0 is stored first.
- par_out  output  WIDTH*J  J output words; word i is par_out[i*WIDTH +: WIDTH]; word 0 is the oldest word.
- empty  output  1  count == 0.
- ready  output  1  free space (DEPTH - count) >= K.
- full  output  1  count == DEPTH.
- valid  output  1  par_out carries a new read result this cycle.

Behaviour:
- State: write pointer, read pointer (both log2(DEPTH) bits), occupancy count (log2(DEPTH)+1 bits), DEPTH x WIDTH storage.
- Reset (rst=0, asynchronous): pointers = 0, count = 0, par_out = 0, valid = 0. Storage contents need not be cleared.
- Outputs after reset: empty=1, full=0, ready=1, valid=0.
- A reset asserted mid-operation discards all buffered data immediately.
- Write accept: w_en=1 and ready=1 at the clock edge.
  - Words 0..K-1 go to addresses wptr..wptr+K-1, modulo DEPTH.
  - wptr advances by K, wrapping modulo DEPTH.
- Write reject: w_en=1 with ready=0 is ignored. No state changes.
- Read accept: r_en=1 and count >= J at the clock edge.
  - Words from rptr..rptr+J-1 (modulo DEPTH) are registered into par_out.
  - rptr advances by J, wrapping modulo DEPTH.
  - valid=1 in the following cycle.
- Read reject: r_en=1 with count < J is ignored. valid=0 and par_out is unchanged.
- Read latency: one clock from accepted r_en to valid/par_out.
- valid is a single-cycle pulse per accepted read. It stays high on consecutive accepted reads.
- par_out holds its last value whenever valid=0.
- Status outputs (empty, ready, full) are combinational from the registered count.
- Simultaneous read and write in the same cycle:
  - Each is accepted independently, based on the pre-edge count.
  - Next count = count + K*wacc - J*racc.
  - Consequence: a write while ready=0 is rejected even if a read frees space in the same cycle.
  - A read and a write never touch the same storage location in one cycle.
- Wrap-around: a K- or J-word access may straddle address DEPTH-1 to address 0. Ordering must be preserved.
- Count never exceeds DEPTH and never goes below 0.

Optional Feature:
- Macro KJ_BUF_ERR_EN.
- When defined:
  - Adds output port err (1 bit).
  - err is sticky: it is set on any rejected request (w_en=1 with ready=0, or r_en=1 with count<J).
  - err is cleared only by reset; its reset value is 0.
- When undefined: err does not exist, and rejected requests are silently dropped.

Test Plan:
- Reset check: hold rst=0, then release -> empty=1, full=0, ready=1, valid=0, par_out=0.
- Fill with default parameters:
  - Stimulus: w_en=1 held for 10 cycles with par_in={8'd10,8'd15,8'd25,8'd12}.
  - Required: exactly 4 writes accepted; count=16, full=1, ready=0, empty=0.
  - With KJ_BUF_ERR_EN defined, err=1 from the 5th cycle.
- Read after fill:
  - Stimulus: r_en=1 for 2 cycles.
  - Required: valid=1 on the two following cycles with par_out=32'h0A0F190C each; then valid=0, count=8, ready=1, full=0.
- Wrap-around:
  - Stimulus: interleave writes of 32'h04030201, 32'h08070605, ... with reads across more than 16 words.
  - Required: par_out returns the same words in write order, with no loss across the address 15 to 0 boundary.
- Simultaneous read and write:
  - At count=12: w_en=r_en=1 -> both accepted, count stays 12.
  - At count=16: w_en=r_en=1 -> read only, count=12.
- Width conversion (K=4, J=2):
  - Stimulus: write 32'h04030201, then read 3 times.
  - Required: par_out=16'h0201, then 16'h0403; the third read is rejected, valid=0, empty=1.
- Reset mid-operation: assert rst=0 while count=8 -> immediately empty=1, valid=0, par_out=0.
